frac_n_ratio_gen: RTL and testbench

- Upstream ratio generator for the fractional PWM divider chain.
- Produces the per-period integer divide ratio N_out, which drives the down-counter divider's N input.
- Dithers between N_int and N_int+1 so the average ratio is N_int + NUM/DEN.
- Configuration is double-buffered and applied only at a period boundary, so divider output periods are never torn.

---
 rtl/frac_n_ratio_gen_pkg.sv | 21 ++
 rtl/frac_acc_stage.sv | 34 +++
 rtl/frac_n_ratio_gen.sv | 141 ++++++++++++++
 tb/tb_frac_n_ratio_gen.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frac_n_ratio_gen_pkg.sv
// Shared constants, reset values and FSM encoding for the fractional-N ratio generator.
// FRAC_MASH2_EN selects the second-order MASH 1-1 dither path.
package frac_n_ratio_gen_pkg;

  localparam int WIDTH_DEF  = 17;
  localparam int FRAC_W_DEF = 16;
  localparam int N_RST      = 2;
  localparam int DEN_RST    = 1;

`ifdef FRAC_MASH2_EN
  localparam int MASH_ORDER = 2;
`else
  localparam int MASH_ORDER = 1;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/frac_acc_stage.sv
// Modulo-DEN phase accumulator with carry; restart forces the step to begin from zero.
module frac_acc_stage #(
  parameter int FRAC_W = 16
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              step,
  input  logic              restart,
  input  logic [FRAC_W-1:0] inc,
  input  logic [FRAC_W-1:0] den,
  output logic [FRAC_W-1:0] acc_nxt,
  output logic              carry
);

  logic [FRAC_W-1:0] acc;
  logic [FRAC_W-1:0] base;
  logic [FRAC_W:0]   sum;
  logic [FRAC_W:0]   wrap;

  always_comb begin
    base    = restart ? '0 : acc;
    sum     = {1'b0, base} + {1'b0, inc};
    wrap    = sum - {1'b0, den};
    carry   = (sum >= {1'b0, den});
    // inc < den and base < den, so one subtraction always lands back in range
    acc_nxt = carry ? wrap[FRAC_W-1:0] : sum[FRAC_W-1:0];
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)       acc <= '0;
    else if (step) acc <= acc_nxt;
  end

endmodule

// File: rtl/frac_n_ratio_gen.sv
// Per-period divide-ratio generator dithering N_int / N_int+1 (or MASH 1-1 when
// FRAC_MASH2_EN is defined), with double-buffered config applied only on period_tick.
module frac_n_ratio_gen
  import frac_n_ratio_gen_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              cfg_load,
  input  logic [WIDTH-1:0]  cfg_n_int,
  input  logic [FRAC_W-1:0] cfg_num,
  input  logic [FRAC_W-1:0] cfg_den,
  input  logic              period_tick,
  output logic [WIDTH-1:0]  N_out,
  output logic              cfg_pending,
  output logic              cfg_err,
  output logic              carry_out
);

  state_t state, state_nxt;
  logic   step;

  logic [WIDTH-1:0]  n_int, sh_n_int, eff_n;
  logic [FRAC_W-1:0] num, den, sh_num, sh_den, eff_num, eff_den;
  logic              apply, cfg_ok;
  logic [WIDTH-1:0]  n_nxt;
  logic [FRAC_W-1:0] acc1_nxt;
  logic              c1;

  // Ratio bounds leave headroom for the largest dither offset.
  localparam logic [WIDTH:0] N_LO = (WIDTH+1)'(MASH_ORDER + 1);
  localparam logic [WIDTH:0] N_HI = {1'b0, {WIDTH{1'b1}}} - (WIDTH+1)'(MASH_ORDER);

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    step      = 1'b0;
    case (state)
      IDLE: if (enable) state_nxt = RUN;
      RUN: begin
        if (!enable) state_nxt = IDLE;
        step = enable && period_tick;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cfg_ok = (cfg_den != '0) && (cfg_num < cfg_den) &&
             ({1'b0, cfg_n_int} >= N_LO) && ({1'b0, cfg_n_int} <= N_HI);
  end

  assign apply   = step && cfg_pending;
  assign eff_n   = apply ? sh_n_int : n_int;
  assign eff_num = apply ? sh_num   : num;
  assign eff_den = apply ? sh_den   : den;

  frac_acc_stage #(.FRAC_W(FRAC_W)) u_acc1 (
    .sys_clk (sys_clk),
    .rst     (rst),
    .step    (step),
    .restart (apply),
    .inc     (eff_num),
    .den     (eff_den),
    .acc_nxt (acc1_nxt),
    .carry   (c1)
  );

`ifdef FRAC_MASH2_EN
  logic [FRAC_W-1:0] acc2_nxt;
  logic              c2, c2_prev, c2_prev_eff;

  // Second stage integrates the first stage's residual.
  frac_acc_stage #(.FRAC_W(FRAC_W)) u_acc2 (
    .sys_clk (sys_clk),
    .rst     (rst),
    .step    (step),
    .restart (apply),
    .inc     (acc1_nxt),
    .den     (eff_den),
    .acc_nxt (acc2_nxt),
    .carry   (c2)
  );

  assign c2_prev_eff = apply ? 1'b0 : c2_prev;
  assign n_nxt = eff_n + WIDTH'(c1) + WIDTH'(c2) - WIDTH'(c2_prev_eff);

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)       c2_prev <= 1'b0;
    else if (step) c2_prev <= c2;
  end
`else
  assign n_nxt = eff_n + WIDTH'(c1);
`endif

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      n_int       <= WIDTH'(N_RST);
      num         <= '0;
      den         <= FRAC_W'(DEN_RST);
      sh_n_int    <= WIDTH'(N_RST);
      sh_num      <= '0;
      sh_den      <= FRAC_W'(DEN_RST);
      cfg_pending <= 1'b0;
      cfg_err     <= 1'b0;
      N_out       <= WIDTH'(N_RST);
      carry_out   <= 1'b0;
    end else begin
      if (step) begin
        if (apply) begin
          n_int       <= sh_n_int;
          num         <= sh_num;
          den         <= sh_den;
          cfg_pending <= 1'b0;
        end
        N_out     <= n_nxt;
        carry_out <= c1;
      end
      // A load in the same cycle as a tick lands after the tick consumed the old shadow.
      if (cfg_load) begin
        if (cfg_ok) begin
          sh_n_int    <= cfg_n_int;
          sh_num      <= cfg_num;
          sh_den      <= cfg_den;
          cfg_pending <= 1'b1;
          cfg_err     <= 1'b0;
        end else begin
          cfg_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_frac_n_ratio_gen.sv
// Scoreboard bench for frac_n_ratio_gen; a behavioural model predicts outputs per cycle.
module tb_frac_n_ratio_gen;

  localparam int WIDTH  = 17;
  localparam int FRAC_W = 16;

  logic              sys_clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic              cfg_load = 1'b0;
  logic [WIDTH-1:0]  cfg_n_int = '0;
  logic [FRAC_W-1:0] cfg_num = '0;
  logic [FRAC_W-1:0] cfg_den = '0;
  logic              period_tick = 1'b0;
  logic [WIDTH-1:0]  N_out;
  logic              cfg_pending, cfg_err, carry_out;

  frac_n_ratio_gen dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .enable      (enable),
    .cfg_load    (cfg_load),
    .cfg_n_int   (cfg_n_int),
    .cfg_num     (cfg_num),
    .cfg_den     (cfg_den),
    .period_tick (period_tick),
    .N_out       (N_out),
    .cfg_pending (cfg_pending),
    .cfg_err     (cfg_err),
    .carry_out   (carry_out)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int   n;
    logic c;
    logic p;
    logic e;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int m_n, m_num, m_den, m_acc, m_sn, m_snum, m_sden, m_last_n;
  int m_acc2, m_c2p;
  bit m_pend, m_err, m_run, m_last_c;

  function automatic void model_reset();
    m_n = 2; m_num = 0; m_den = 1; m_acc = 0;
    m_sn = 2; m_snum = 0; m_sden = 1;
    m_acc2 = 0; m_c2p = 0;
    m_pend = 0; m_err = 0; m_run = 0;
    m_last_n = 2; m_last_c = 0;
  endfunction

  function automatic bit cfg_valid(input int n, input int nu, input int de);
`ifdef FRAC_MASH2_EN
    return (de != 0) && (nu < de) && (n >= 3) && (n <= 131069);
`else
    return (de != 0) && (nu < de) && (n >= 2) && (n != 131071);
`endif
  endfunction

  // One clock: drive inputs, advance the model, push expected post-edge outputs.
  task automatic drive(input bit tk, input bit ld, input int n, input int nu, input int de);
    exp_t e;
    int   sum;
    bit   c;
    period_tick = tk;
    cfg_load    = ld;
    cfg_n_int   = WIDTH'(n);
    cfg_num     = FRAC_W'(nu);
    cfg_den     = FRAC_W'(de);
    if (m_run && enable && tk) begin
      if (m_pend) begin
        m_n = m_sn; m_num = m_snum; m_den = m_sden;
        m_acc = 0; m_acc2 = 0; m_c2p = 0; m_pend = 0;
      end
      sum = m_acc + m_num;
      c = (sum >= m_den);
      m_acc = c ? sum - m_den : sum;
`ifdef FRAC_MASH2_EN
      begin
        int s2;
        bit c2;
        s2 = m_acc2 + m_acc;
        c2 = (s2 >= m_den);
        m_acc2 = c2 ? s2 - m_den : s2;
        m_last_n = m_n + int'(c) + int'(c2) - m_c2p;
        m_c2p = int'(c2);
      end
`else
      m_last_n = m_n + int'(c);
`endif
      m_last_c = c;
    end
    if (ld) begin
      if (cfg_valid(n, nu, de)) begin
        m_sn = n; m_snum = nu; m_sden = de; m_pend = 1; m_err = 0;
      end else begin
        m_err = 1;
      end
    end
    m_run = enable;
    e.n = m_last_n; e.c = m_last_c; e.p = m_pend; e.e = m_err;
    sb.push_back(e);
    @(posedge sys_clk);
    #1;
    period_tick = 1'b0;
    cfg_load    = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge sys_clk);
    #1;
    n_cmp++;
    if (N_out !== 17'd2 || carry_out !== 1'b0 || cfg_pending !== 1'b0 || cfg_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: N_out=%0d carry=%b pend=%b err=%b, required 2/0/0/0",
               N_out, carry_out, cfg_pending, cfg_err);
    end
    rst = 1'b0;
    enable = 1'b1;
    drive(0, 0, 0, 0, 0);
    void'(sb.pop_front());
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, 0);
      e = sb.pop_front();
      n_cmp++;
      if (N_out !== 17'd2 || N_out !== WIDTH'(e.n) || cfg_pending !== 1'b0) begin
        n_bad++;
        $display("FAIL default_ratio[%0d]: N_out=%0d pend=%b, required 2/0", i, N_out, cfg_pending);
      end
    end
  endtask

  task automatic test_dither();
    exp_t e;
    int   total = 0;
    drive(0, 1, 100, 1, 4);
    void'(sb.pop_front());
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 0, 0, 0);
      e = sb.pop_front();
      total += int'(N_out);
      n_cmp++;
      if (N_out !== WIDTH'(e.n) || carry_out !== e.c || cfg_pending !== e.p) begin
        n_bad++;
        $display("FAIL dither[%0d]: N_out=%0d carry=%b pend=%b, required %0d/%b/%b",
                 i, N_out, carry_out, cfg_pending, e.n, e.c, e.p);
      end
    end
    n_cmp++;
    if (total != 802) begin
      n_bad++;
      $display("FAIL dither_sum: got %0d, required 802", total);
    end
  endtask

  task automatic test_reject();
    exp_t e;
    int   bad_tab[4][3] = '{'{100, 5, 5}, '{100, 0, 0}, '{1, 0, 1}, '{131071, 0, 1}};
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, bad_tab[i][0], bad_tab[i][1], bad_tab[i][2]);
      e = sb.pop_front();
      n_cmp++;
      if (cfg_err !== 1'b1 || cfg_err !== e.e || cfg_pending !== e.p || N_out !== WIDTH'(e.n)) begin
        n_bad++;
        $display("FAIL reject[%0d]: err=%b pend=%b N_out=%0d, required 1/%b/%0d",
                 i, cfg_err, cfg_pending, N_out, e.p, e.n);
      end
    end
    // Active config must still be 100 + 1/4: next tick continues that pattern.
    drive(1, 0, 0, 0, 0);
    e = sb.pop_front();
    n_cmp++;
    if (N_out !== WIDTH'(e.n) || carry_out !== e.c) begin
      n_bad++;
      $display("FAIL reject_keep: N_out=%0d carry=%b, required %0d/%b", N_out, carry_out, e.n, e.c);
    end
    drive(0, 1, 100, 3, 7);
    e = sb.pop_front();
    n_cmp++;
    if (cfg_err !== 1'b0 || cfg_pending !== 1'b1) begin
      n_bad++;
      $display("FAIL accept: err=%b pend=%b, required 0/1", cfg_err, cfg_pending);
    end
    drive(1, 0, 0, 0, 0);
    e = sb.pop_front();
    n_cmp++;
    if (cfg_pending !== 1'b0 || N_out !== WIDTH'(e.n) || carry_out !== e.c) begin
      n_bad++;
      $display("FAIL accept_apply: pend=%b N_out=%0d, required 0/%0d", cfg_pending, N_out, e.n);
    end
  endtask

  task automatic test_same_cycle();
    exp_t e;
    drive(0, 1, 50, 1, 2);
    void'(sb.pop_front());
    drive(1, 0, 0, 0, 0);
    void'(sb.pop_front());
    drive(1, 1, 60, 1, 2);
    e = sb.pop_front();
    n_cmp++;
    if (N_out < 17'd50 || N_out > 17'd51 || N_out !== WIDTH'(e.n) || cfg_pending !== 1'b1) begin
      n_bad++;
      $display("FAIL same_cycle_old: N_out=%0d pend=%b, required %0d/1", N_out, cfg_pending, e.n);
    end
    drive(1, 0, 0, 0, 0);
    e = sb.pop_front();
    n_cmp++;
    if (N_out < 17'd60 || N_out > 17'd61 || N_out !== WIDTH'(e.n) || cfg_pending !== 1'b0) begin
      n_bad++;
      $display("FAIL same_cycle_new: N_out=%0d pend=%b, required %0d/0", N_out, cfg_pending, e.n);
    end
  endtask

  task automatic test_hold();
    exp_t e;
    drive(0, 1, 10, 1, 3);
    void'(sb.pop_front());
    drive(1, 0, 0, 0, 0);
    void'(sb.pop_front());
    drive(1, 0, 0, 0, 0);
    void'(sb.pop_front());
    enable = 1'b0;
    drive(0, 0, 0, 0, 0);
    void'(sb.pop_front());
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 0, 0);
      e = sb.pop_front();
      n_cmp++;
      if (N_out !== 17'd10 || N_out !== WIDTH'(e.n)) begin
        n_bad++;
        $display("FAIL hold[%0d]: N_out=%0d, required 10", i, N_out);
      end
    end
    enable = 1'b1;
    drive(0, 0, 0, 0, 0);
    void'(sb.pop_front());
    // Phase was 2/3 before the hold, so the next tick must carry.
    drive(1, 0, 0, 0, 0);
    e = sb.pop_front();
    n_cmp++;
    if (N_out !== 17'd11 || carry_out !== 1'b1 || N_out !== WIDTH'(e.n)) begin
      n_bad++;
      $display("FAIL hold_resume: N_out=%0d carry=%b, required 11/1", N_out, carry_out);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   total = 0;
    drive(0, 1, 20, 2, 3);
    void'(sb.pop_front());
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 0, 0, 0);
      e = sb.pop_front();
      total += int'(N_out);
      n_cmp++;
      if (N_out !== WIDTH'(e.n) || carry_out !== e.c) begin
        n_bad++;
        $display("FAIL b2b[%0d]: N_out=%0d carry=%b, required %0d/%b", i, N_out, carry_out, e.n, e.c);
      end
    end
    n_cmp++;
    if (total != 124) begin
      n_bad++;
      $display("FAIL b2b_sum: got %0d, required 124", total);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    drive(0, 1, 77, 1, 2);
    void'(sb.pop_front());
    #2 rst = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if (N_out !== 17'd2 || cfg_pending !== 1'b0 || carry_out !== 1'b0 || cfg_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid: N_out=%0d pend=%b carry=%b err=%b, required 2/0/0/0",
               N_out, cfg_pending, carry_out, cfg_err);
    end
    @(posedge sys_clk);
    #1 rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    void'(sb.pop_front());
    drive(1, 0, 0, 0, 0);
    e = sb.pop_front();
    n_cmp++;
    if (N_out !== 17'd2 || N_out !== WIDTH'(e.n) || cfg_pending !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_discard: N_out=%0d pend=%b, required 2/0", N_out, cfg_pending);
    end
  endtask

`ifdef FRAC_MASH2_EN
  task automatic test_mash();
    exp_t e;
    int   total = 0;
    drive(0, 1, 1000, 1, 16);
    void'(sb.pop_front());
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 0, 0, 0);
      e = sb.pop_front();
      total += int'(N_out);
      n_cmp++;
      if (N_out < 17'd999 || N_out > 17'd1002 || N_out !== WIDTH'(e.n)) begin
        n_bad++;
        $display("FAIL mash[%0d]: N_out=%0d, required %0d in 999..1002", i, N_out, e.n);
      end
    end
    n_cmp++;
    if (total != 16001) begin
      n_bad++;
      $display("FAIL mash_sum: got %0d, required 16001", total);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_dither();
    test_reject();
    test_same_cycle();
    test_hold();
    test_back_to_back();
    test_reset_mid();
`ifdef FRAC_MASH2_EN
    test_mash();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
